// File: rtl/pms_loader.sv
// -----------------------------------------------------------------------------
// pms_loader
//
// Purpose
//   Writer side of the program memory that the program management system
//   fetches from. A framed byte stream arriving on the host byte link is
//   unpacked into 16-bit words and written through a request/acknowledge
//   memory write port. The processor is held (cpu_hold) until a complete
//   frame has been written and its checksum matches, then it is released.
//
//   Frame layout (one byte per accepted rx beat):
//     SYNC_BYTE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO,
//     CNT words sent as HI byte then LO byte, CSUM
//   CSUM is the XOR of the 2*CNT data bytes only (header bytes excluded).
//
// Parameters
//   SYNC_BYTE       frame start marker (default 8'hA5)
//   TIMEOUT_CYCLES  idle cycles allowed between bytes inside a frame before
//                   the frame is abandoned; only used when the macro
//                   LOADER_TIMEOUT_EN is defined
//
// Build option
//   LOADER_TIMEOUT_EN  when defined, a 16-bit idle counter aborts a stalled
//                      frame into the error state. When undefined the loader
//                      waits indefinitely in every state.
//
// Ports
//   clk        in   1   single clock, rising edge
//   reset      in   1   synchronous reset, active low (0 = reset)
//   load_req   in   1   one-cycle pulse, restarts loading from DONE
//   rx_data    in   8   stream byte
//   rx_valid   in   1   rx_data valid
//   rx_ready   out  1   byte accepted when rx_valid & rx_ready
//   mem_addr   out 16   write address
//   mem_wdata  out 16   write data
//   mem_we     out  1   write request, held until mem_ack
//   mem_ack    in   1   write accepted this cycle
//   cpu_hold   out  1   1 = processor held
//   done       out  1   last frame loaded with a good checksum
//   error      out  1   last frame failed; sticky until next SYNC_BYTE
// -----------------------------------------------------------------------------
module pms_loader #(
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load_req,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_we,
   input  logic        mem_ack,
   output logic        cpu_hold,
   output logic        done,
   output logic        error
);

   // Encoding order matters: AH..CK form a contiguous range that the idle
   // timer uses to decide when it is armed.
   localparam logic [3:0] ST_SYNC = 4'd0;
   localparam logic [3:0] ST_AH   = 4'd1;
   localparam logic [3:0] ST_AL   = 4'd2;
   localparam logic [3:0] ST_CH   = 4'd3;
   localparam logic [3:0] ST_CL   = 4'd4;
   localparam logic [3:0] ST_DH   = 4'd5;
   localparam logic [3:0] ST_DL   = 4'd6;
   localparam logic [3:0] ST_WR   = 4'd7;
   localparam logic [3:0] ST_CK   = 4'd8;
   localparam logic [3:0] ST_DONE = 4'd9;
   localparam logic [3:0] ST_ERR  = 4'd10;

   logic [3:0]  state_reg,  state_next;
   logic [15:0] addr_reg,   addr_next;
   logic [15:0] wdata_reg,  wdata_next;
   logic        we_reg,     we_next;
   logic [15:0] count_reg,  count_next;   // words still to be written
   logic [7:0]  csum_reg,   csum_next;    // running XOR of data bytes
   logic [7:0]  hi_reg,     hi_next;      // holds the first byte of a 16-bit field
   logic        error_reg,  error_next;

   logic        accept;

`ifdef LOADER_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] idle_reg, idle_next;
   logic        in_frame;
`endif

   // The loader only refuses bytes while a write is outstanding or after a
   // successful load (until load_req). Everything else consumes bytes.
   assign rx_ready  = (state_reg != ST_WR) && (state_reg != ST_DONE);
   assign accept    = rx_valid && rx_ready;

   assign mem_addr  = addr_reg;
   assign mem_wdata = wdata_reg;
   assign mem_we    = we_reg;
   assign done      = (state_reg == ST_DONE);
   assign cpu_hold  = (state_reg != ST_DONE);
   assign error     = error_reg;

   always_comb begin
      state_next = state_reg;
      addr_next  = addr_reg;
      wdata_next = wdata_reg;
      we_next    = we_reg;
      count_next = count_reg;
      csum_next  = csum_reg;
      hi_next    = hi_reg;
      error_next = error_reg;

      case (state_reg)
         // ERR behaves like SYNC except that error stays set until a new
         // frame actually starts.
         ST_SYNC, ST_ERR: begin
            if (accept && (rx_data == SYNC_BYTE)) begin
               state_next = ST_AH;
               error_next = 1'b0;
               csum_next  = 8'h00;
            end
         end

         ST_AH: begin
            if (accept) begin
               hi_next    = rx_data;
               state_next = ST_AL;
            end
         end

         ST_AL: begin
            if (accept) begin
               addr_next  = {hi_reg, rx_data};
               state_next = ST_CH;
            end
         end

         ST_CH: begin
            if (accept) begin
               hi_next    = rx_data;
               state_next = ST_CL;
            end
         end

         ST_CL: begin
            if (accept) begin
               count_next = {hi_reg, rx_data};
               // An empty frame still carries a checksum byte (XOR of nothing = 0).
               state_next = ({hi_reg, rx_data} == 16'h0000) ? ST_CK : ST_DH;
            end
         end

         ST_DH: begin
            if (accept) begin
               hi_next    = rx_data;
               csum_next  = csum_reg ^ rx_data;
               state_next = ST_DL;
            end
         end

         ST_DL: begin
            if (accept) begin
               wdata_next = {hi_reg, rx_data};
               csum_next  = csum_reg ^ rx_data;
               we_next    = 1'b1;
               state_next = ST_WR;
            end
         end

         // we_reg is always high here, so mem_ack alone qualifies the write.
         ST_WR: begin
            if (mem_ack) begin
               we_next    = 1'b0;
               addr_next  = addr_reg + 16'd1;   // wraps FFFF -> 0000 naturally
               count_next = count_reg - 16'd1;
               state_next = (count_reg == 16'd1) ? ST_CK : ST_DH;
            end
         end

         ST_CK: begin
            if (accept) begin
               if (rx_data == csum_reg) begin
                  state_next = ST_DONE;
               end else begin
                  state_next = ST_ERR;
                  error_next = 1'b1;
               end
            end
         end

         ST_DONE: begin
            if (load_req) begin
               state_next = ST_SYNC;
            end
         end

         default: begin
            state_next = ST_SYNC;
            we_next    = 1'b0;
         end
      endcase

`ifdef LOADER_TIMEOUT_EN
      // The idle timer runs only while a frame is in progress. Any accepted
      // byte or write acknowledge counts as activity. On expiry the frame is
      // abandoned, overriding whatever the state decode chose above; that can
      // only happen in a cycle with no activity, so no transfer is lost.
      in_frame  = (state_reg >= ST_AH) && (state_reg <= ST_CK);
      idle_next = 16'h0000;
      if (in_frame && !accept && !(mem_ack && we_reg)) begin
         if (idle_reg == TIMEOUT_LAST) begin
            state_next = ST_ERR;
            error_next = 1'b1;
            we_next    = 1'b0;
         end else begin
            idle_next = idle_reg + 16'd1;
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg <= ST_SYNC;
         addr_reg  <= 16'h0000;
         wdata_reg <= 16'h0000;
         we_reg    <= 1'b0;
         count_reg <= 16'h0000;
         csum_reg  <= 8'h00;
         hi_reg    <= 8'h00;
         error_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         addr_reg  <= addr_next;
         wdata_reg <= wdata_next;
         we_reg    <= we_next;
         count_reg <= count_next;
         csum_reg  <= csum_next;
         hi_reg    <= hi_next;
         error_reg <= error_next;
      end
   end

`ifdef LOADER_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         idle_reg <= 16'h0000;
      end else begin
         idle_reg <= idle_next;
      end
   end
`endif

endmodule

// File: tb/tb_pms_loader.sv
// -----------------------------------------------------------------------------
// tb_pms_loader
//
// Directed bench for pms_loader. A small memory responder acknowledges write
// requests after a programmable delay and logs every completed write (address,
// data, number of cycles mem_we was held). Frames are pushed byte by byte and
// the resulting writes and status outputs are compared with hand-computed
// values. Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_pms_loader;

`ifdef LOADER_TIMEOUT_EN
   localparam int unsigned TB_TIMEOUT = 16;
`else
   localparam int unsigned TB_TIMEOUT = 65535;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        load_req;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_we;
   logic        mem_ack = 1'b0;
   logic        cpu_hold;
   logic        done;
   logic        error;

   int checks   = 0;
   int failures = 0;

   // memory responder state
   int          ack_delay = 0;
   int          wait_cnt  = 0;
   int          we_run    = 0;
   int          rdy_viol  = 0;
   logic [15:0] wr_addr_q[$];
   logic [15:0] wr_data_q[$];
   int          wr_run_q[$];

   logic [7:0]  fr[$];

   always #5 clk = ~clk;

   pms_loader #(
      .SYNC_BYTE      (8'hA5),
      .TIMEOUT_CYCLES (TB_TIMEOUT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .load_req  (load_req),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_ack   (mem_ack),
      .cpu_hold  (cpu_hold),
      .done      (done),
      .error     (error)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Acknowledge after ack_delay waiting cycles; log the write at the ack cycle.
   always @(negedge clk) begin
      if (mem_we) begin
         we_run = we_run + 1;
         if (rx_ready) rdy_viol = rdy_viol + 1;
         if (wait_cnt >= ack_delay) begin
            mem_ack = 1'b1;
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
            wr_run_q.push_back(we_run);
            wait_cnt = 0;
            we_run   = 0;
         end else begin
            mem_ack  = 1'b0;
            wait_cnt = wait_cnt + 1;
         end
      end else begin
         mem_ack  = 1'b0;
         wait_cnt = 0;
         we_run   = 0;
      end
   end

   // Called at a falling edge; returns at the falling edge after acceptance.
   task automatic send_byte(input logic [7:0] b);
      int n;
      rx_data  = b;
      rx_valid = 1'b1;
      n = 0;
      while (!rx_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!rx_ready) begin
         check("rx_ready_wait", 32'(rx_ready), 1);
      end else begin
         @(negedge clk);
      end
      rx_valid = 1'b0;
   endtask

   task automatic send_frame();
      for (int i = 0; i < fr.size(); i++) send_byte(fr[i]);
      fr.delete();
   endtask

   task automatic pulse_load();
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
   endtask

   task automatic clear_log();
      wr_addr_q.delete();
      wr_data_q.delete();
      wr_run_q.delete();
      rdy_viol = 0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset    = 1'b0;
      load_req = 1'b0;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      repeat (3) @(negedge clk);

      // reset state
      check("rst_rx_ready",  32'(rx_ready),  1);
      check("rst_mem_we",    32'(mem_we),    0);
      check("rst_mem_addr",  32'(mem_addr),  0);
      check("rst_mem_wdata", 32'(mem_wdata), 0);
      check("rst_cpu_hold",  32'(cpu_hold),  1);
      check("rst_done",      32'(done),      0);
      check("rst_error",     32'(error),     0);
      reset = 1'b1;
      @(negedge clk);

      // basic frame, immediate ack; checksum 12^34^AB^CD = 40
      clear_log();
      ack_delay = 0;
      fr = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
      send_frame();
      check("f1_done",     32'(done),     1);
      check("f1_cpu_hold", 32'(cpu_hold), 0);
      check("f1_rx_ready", 32'(rx_ready), 0);
      check("f1_nwr",      32'(wr_addr_q.size()), 2);
      check("f1_addr0",    32'(wr_addr_q[0]), 32'h0100);
      check("f1_data0",    32'(wr_data_q[0]), 32'h1234);
      check("f1_addr1",    32'(wr_addr_q[1]), 32'h0101);
      check("f1_data1",    32'(wr_data_q[1]), 32'hABCD);
      $display("frame1: writes=%0d done=%0d", wr_addr_q.size(), done);

      pulse_load();
      check("reload_cpu_hold", 32'(cpu_hold), 1);
      check("reload_done",     32'(done),     0);
      check("reload_rx_ready", 32'(rx_ready), 1);

      // bad checksum, then recovery
      clear_log();
      fr = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00};
      send_frame();
      check("bad_error",    32'(error),    1);
      check("bad_done",     32'(done),     0);
      check("bad_cpu_hold", 32'(cpu_hold), 1);
      send_byte(8'h33);
      check("bad_sticky",   32'(error),    1);
      fr = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
      send_frame();
      check("rec_done",  32'(done),  1);
      check("rec_error", 32'(error), 0);
      check("rec_nwr",   32'(wr_addr_q.size()), 4);
      $display("bad+recover: error=%0d done=%0d", error, done);

      // garbage before sync, empty frame
      pulse_load();
      clear_log();
      fr = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      send_frame();
      check("empty_done", 32'(done), 1);
      check("empty_nwr",  32'(wr_addr_q.size()), 0);
      $display("empty frame: writes=%0d done=%0d", wr_addr_q.size(), done);

      // address wrap with delayed ack; checksum 11^22^33^44 = 44
      pulse_load();
      clear_log();
      ack_delay = 3;
      fr = '{8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
      send_frame();
      check("wrap_nwr",   32'(wr_addr_q.size()), 2);
      check("wrap_addr0", 32'(wr_addr_q[0]), 32'hFFFF);
      check("wrap_addr1", 32'(wr_addr_q[1]), 32'h0000);
      check("wrap_data0", 32'(wr_data_q[0]), 32'h1122);
      check("wrap_data1", 32'(wr_data_q[1]), 32'h3344);
      check("wrap_run0",  32'(wr_run_q[0]), 4);
      check("wrap_run1",  32'(wr_run_q[1]), 4);
      check("wrap_rdy_in_wr", 32'(rdy_viol), 0);
      check("wrap_done",  32'(done), 1);
      $display("wrap: addr0=%h addr1=%h run0=%0d", wr_addr_q[0], wr_addr_q[1], wr_run_q[0]);

      // idle stall after ADDR_HI
      pulse_load();
      clear_log();
      ack_delay = 0;
      send_byte(8'hA5);
      send_byte(8'h01);
      repeat (10) @(negedge clk);
      check("stall10_error", 32'(error), 0);
`ifdef LOADER_TIMEOUT_EN
      repeat (10) @(negedge clk);
      check("tmo_error",    32'(error),    1);
      check("tmo_cpu_hold", 32'(cpu_hold), 1);
      fr = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
      send_frame();
      check("tmo_rec_done",  32'(done),  1);
      check("tmo_rec_error", 32'(error), 0);
      $display("timeout: recovered done=%0d", done);
`else
      repeat (30) @(negedge clk);
      check("stall40_error", 32'(error), 0);
      fr = '{8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
      send_frame();
      check("stall_done",  32'(done), 1);
      check("stall_addr0", 32'(wr_addr_q[0]), 32'h0100);
      $display("stall: done=%0d", done);
`endif

      // reset asserted while a write is outstanding
      pulse_load();
      clear_log();
      ack_delay = 5;
      fr = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h04, 8'hAA, 8'hBB};
      send_frame();
      check("mid_we_before", 32'(mem_we), 1);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("mid_we",       32'(mem_we),    0);
      check("mid_cpu_hold", 32'(cpu_hold),  1);
      check("mid_rx_ready", 32'(rx_ready),  1);
      check("mid_addr",     32'(mem_addr),  0);
      check("mid_wdata",    32'(mem_wdata), 0);
      check("mid_done",     32'(done),      0);
      @(negedge clk);
      check("mid_nwr", 32'(wr_addr_q.size()), 0);
      ack_delay = 0;
      fr = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
      send_frame();
      check("post_rst_done",     32'(done),     1);
      check("post_rst_cpu_hold", 32'(cpu_hold), 0);
      pulse_load();
      check("final_cpu_hold", 32'(cpu_hold), 1);
      check("final_done",     32'(done),     0);
      $display("reset mid-write: recovered, cpu_hold=%0d", cpu_hold);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
